// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one 64-bit read or write frame per start
// request on MDC/MDIO and returns the read data with a one-cycle done pulse.
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_mdc,
    inout  wire         io_mdio
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_TA       = 3'd3,
        S_DATA     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        bit_q, bit_d, bit_nx_s;
    logic [63:0]       frame_q, frame_d;
    logic [15:0]       shift_q, shift_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              mdc_q, mdc_d;
    logic              oe_q, oe_d;
    logic              mdo_q, mdo_d;
    logic              write_q, write_d;
    logic              ta_err_q, ta_err_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    function automatic state_t bit_state(input logic [5:0] b);
        if (b < 6'd32) begin
            return S_PREAMBLE;
        end else if (b < 6'd46) begin
            return S_HEADER;
        end else if (b < 6'd48) begin
            return S_TA;
        end else begin
            return S_DATA;
        end
    endfunction

    assign bit_nx_s = bit_q + 6'd1;

    // Frame sequencing: MDC divider, bit advance on MDC fall, capture on MDC rise.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        mdc_d    = mdc_q;
        oe_d     = oe_q;
        mdo_d    = mdo_q;
        write_d  = write_q;
        ta_err_d = ta_err_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_PREAMBLE;
                    busy_d   = 1'b1;
                    div_d    = {DIV_W{1'b0}};
                    bit_d    = 6'd0;
                    mdc_d    = 1'b0;
                    oe_d     = 1'b1;
                    mdo_d    = 1'b1;
                    write_d  = i_write;
                    err_d    = 1'b0;
                    ta_err_d = 1'b0;
                    shift_d  = 16'h0000;
                    frame_d  = {32'hFFFF_FFFF, 2'b01, (i_write ? 2'b01 : 2'b10),
                                i_phy_addr, i_reg_addr, (i_write ? 2'b10 : 2'b11),
                                (i_write ? i_wdata : 16'hFFFF)};
                end else begin
                    oe_d  = 1'b0;
                    mdc_d = 1'b0;
                end
            end
            S_PREAMBLE, S_HEADER, S_TA, S_DATA: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else if (!mdc_q) begin
                    div_d = {DIV_W{1'b0}};
                    mdc_d = 1'b1;
                    if (bit_q == 6'd47) begin
                        ta_err_d = io_mdio;
                    end else if (bit_q >= 6'd48) begin
                        shift_d = {shift_q[14:0], io_mdio};
                    end else begin
                        shift_d = shift_q;
                    end
                end else if (bit_q == 6'd63) begin
                    div_d   = {DIV_W{1'b0}};
                    mdc_d   = 1'b0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        rdata_d = shift_q;
                        err_d   = ta_err_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    // A read hands the line to the PHY from the first TA bit on.
                    div_d   = {DIV_W{1'b0}};
                    mdc_d   = 1'b0;
                    bit_d   = bit_nx_s;
                    state_d = bit_state(bit_nx_s);
                    frame_d = {frame_q[62:0], 1'b0};
                    mdo_d   = frame_q[62];
                    oe_d    = write_q || (bit_nx_s < 6'd46);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                mdc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            div_q    <= {DIV_W{1'b0}};
            bit_q    <= 6'd0;
            frame_q  <= 64'd0;
            shift_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            mdc_q    <= 1'b0;
            oe_q     <= 1'b0;
            mdo_q    <= 1'b1;
            write_q  <= 1'b0;
            ta_err_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            mdc_q    <= mdc_d;
            oe_q     <= oe_d;
            mdo_q    <= mdo_d;
            write_q  <= write_d;
            ta_err_q <= ta_err_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign io_mdio = oe_q ? mdo_q : 1'bz;
    assign o_mdc   = mdc_q;
    assign o_rdata = rdata_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_err   = err_q;
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (CLK_DIV 10 and 1), each with a pulled-up
// MDIO line and a behavioural PHY at address 0; done events checked by a scoreboard.
module tb_mdio_master;
    localparam int CD_A = 10;
    localparam int CD_B = 1;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_v;
    logic [1:0]  start_v;
    logic [1:0]  wr_v;
    logic [4:0]  pa_v [2];
    logic [4:0]  ra_v [2];
    logic [15:0] wd_v [2];

    wire [15:0] rdata_a, rdata_b;
    wire        done_a, done_b, busy_a, busy_b, err_a, err_b, mdc_a, mdc_b;
    wire        mdio_a, mdio_b;
    wire [1:0]  done_w = {done_b, done_a};
    wire [1:0]  busy_w = {busy_b, busy_a};
    wire [1:0]  mdc_w  = {mdc_b, mdc_a};
    wire [1:0]  mdio_w = {mdio_b, mdio_a};

    logic [1:0]  phy_oe, phy_val, present, prev_mdc, prev_busy;
    logic [15:0] phy_data [2];
    logic [63:0] cap [2];
    logic [63:0] lastcap [2];
    logic [13:0] hdr [2];
    int          cnt [2];
    int          frames [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    pullup (mdio_a);
    pullup (mdio_b);
    assign mdio_a = phy_oe[0] ? phy_val[0] : 1'bz;
    assign mdio_b = phy_oe[1] ? phy_val[1] : 1'bz;

    mdio_master #(.CLK_DIV(CD_A)) dut_a (
        .clk(clk), .i_reset_n(rst_v[0]), .i_start(start_v[0]), .i_write(wr_v[0]),
        .i_phy_addr(pa_v[0]), .i_reg_addr(ra_v[0]), .i_wdata(wd_v[0]),
        .o_rdata(rdata_a), .o_done(done_a), .o_busy(busy_a), .o_err(err_a),
        .o_mdc(mdc_a), .io_mdio(mdio_a)
    );

    mdio_master #(.CLK_DIV(CD_B)) dut_b (
        .clk(clk), .i_reset_n(rst_v[1]), .i_start(start_v[1]), .i_write(wr_v[1]),
        .i_phy_addr(pa_v[1]), .i_reg_addr(ra_v[1]), .i_wdata(wd_v[1]),
        .o_rdata(rdata_b), .o_done(done_b), .o_busy(busy_b), .o_err(err_b),
        .o_mdc(mdc_b), .io_mdio(mdio_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever @(posedge clk) cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // PHY model: captures on MDC rise, drives read turnaround/data after MDC fall.
    initial begin
        phy_oe = 2'b00; phy_val = 2'b11; prev_mdc = 2'b00; prev_busy = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; frames[i] = 0; cap[i] = 64'd0; lastcap[i] = 64'd0; hdr[i] = 14'd0;
        end
        forever @(negedge clk) begin
            for (int i = 0; i < 2; i++) begin
                if (!busy_w[i]) begin
                    cnt[i] = 0;
                    phy_oe[i] = 1'b0;
                    if (prev_busy[i]) begin
                        lastcap[i] = cap[i];
                        frames[i]++;
                    end
                end else if (mdc_w[i] && !prev_mdc[i]) begin
                    if (cnt[i] == 45) hdr[i] = {cap[i][12:0], mdio_w[i]};
                    cap[i] = {cap[i][62:0], mdio_w[i]};
                    cnt[i]++;
                end else if (!mdc_w[i] && prev_mdc[i]) begin
                    if (present[i] && hdr[i][11:10] == 2'b10 && hdr[i][9:5] == 5'd0 &&
                        cnt[i] >= 47 && cnt[i] <= 63) begin
                        phy_oe[i]  = 1'b1;
                        phy_val[i] = (cnt[i] == 47) ? 1'b0 : phy_data[i][63 - cnt[i]];
                    end else begin
                        phy_oe[i] = 1'b0;
                    end
                end
                prev_mdc[i]  = mdc_w[i];
                prev_busy[i] = busy_w[i];
            end
        end
    end

    task automatic mon(input int d);
        exp_t        e;
        logic [15:0] rd;
        logic        er, bz, mc;
        rd = (d == 0) ? rdata_a : rdata_b;
        er = (d == 0) ? err_a : err_b;
        bz = busy_w[d];
        mc = mdc_w[d];
        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL done%0d_unexpected: got o_done=1 at cycle %0d, required no frame end", d, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("rdata%0d", d), {48'd0, rd}, {48'd0, e.rdata});
            chk($sformatf("err%0d", d), {63'd0, er}, {63'd0, e.err});
            chk($sformatf("done_time%0d", d), cyc, e.t);
            chk($sformatf("busy_at_done%0d", d), {63'd0, bz}, 64'd0);
            chk($sformatf("mdc_at_done%0d", d), {63'd0, mc}, 64'd0);
        end
    endtask

    // Scoreboard monitor: every done pulse is matched against the expected queue.
    initial begin
        forever @(negedge clk) begin
            if (done_a) mon(0);
            if (done_b) mon(1);
        end
    end

    task automatic issue(input int d, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit push, input logic [15:0] er, input logic ee);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        e.t     = cyc + 1 + 128 * ((d == 0) ? CD_A : CD_B);
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        start_v[d] = 1'b1; wr_v[d] = wr; pa_v[d] = pa; ra_v[d] = ra; wd_v[d] = wd;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input string name);
        int k;
        k = 0;
        while ((busy_w[d] || ((d == 0) ? q0.size() : q1.size()) != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 3000) begin
            errors++;
            $display("FAIL timeout_%s: got no frame end within %0d cycles, required o_done", name, k);
        end
    endtask

    initial begin
        int a0, f0;
        rst_v = 2'b00; start_v = 2'b00; wr_v = 2'b00; present = 2'b11;
        phy_data[0] = 16'h1234; phy_data[1] = 16'h8001;
        for (int i = 0; i < 2; i++) begin
            pa_v[i] = 5'd0; ra_v[i] = 5'd0; wd_v[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        rst_v = 2'b11;
        @(negedge clk);
        chk("rst_busy", {62'd0, busy_w}, 64'd0);
        chk("rst_done", {62'd0, done_w}, 64'd0);
        chk("rst_mdc", {62'd0, mdc_w}, 64'd0);
        chk("rst_err", {62'd0, err_b, err_a}, 64'd0);
        chk("rst_rdata", {32'd0, rdata_b, rdata_a}, 64'd0);
        chk("rst_mdio_released", {62'd0, mdio_w}, 64'd3);

        // CLK_DIV=1 read on instance B
        issue(1, 1'b0, 5'd0, 5'd2, 16'h0000, 1'b1, 16'h8001, 1'b0);
        chk("b_mdc_t0", {63'd0, mdc_b}, 64'd0);
        @(negedge clk);
        chk("b_mdc_t1", {63'd0, mdc_b}, 64'd1);
        @(negedge clk);
        chk("b_mdc_t2", {63'd0, mdc_b}, 64'd0);
        wait_idle(1, "b_read");

        // read 0x1234 from PHY 0 reg 2
        issue(0, 1'b0, 5'd0, 5'd2, 16'h0000, 1'b1, 16'h1234, 1'b0);
        wait_idle(0, "read1");
        chk("read_header", {18'd0, lastcap[0][63:18]}, {18'd0, 32'hFFFF_FFFF, 4'b0110, 5'd0, 5'd2});
        chk("read_bus_data", {48'd0, lastcap[0][15:0]}, 64'h1234);

        // write keeps rdata
        issue(0, 1'b1, 5'd3, 5'h1F, 16'hA5C3, 1'b1, 16'h1234, 1'b0);
        wait_idle(0, "write1");
        chk("write_frame", lastcap[0], {32'hFFFF_FFFF, 4'b0101, 5'd3, 5'h1F, 2'b10, 16'hA5C3});

        // no PHY: pull-up only
        present[0] = 1'b0;
        issue(0, 1'b0, 5'd0, 5'd2, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
        wait_idle(0, "nophy");
        present[0] = 1'b1;

        // write after error: err cleared on accept, rdata kept
        issue(0, 1'b1, 5'd0, 5'd4, 16'h0F0F, 1'b1, 16'hFFFF, 1'b0);
        chk("err_cleared_on_accept", {63'd0, err_a}, 64'd0);
        wait_idle(0, "write2");

        // starts while busy and in the done cycle are ignored
        f0 = frames[0];
        issue(0, 1'b0, 5'd0, 5'd2, 16'h0000, 1'b1, 16'h1234, 1'b0);
        a0 = cyc;
        while (cyc < a0 + 4) @(negedge clk);
        issue(0, 1'b1, 5'd1, 5'd1, 16'h5555, 1'b0, 16'h0000, 1'b0);
        while (cyc < a0 + 1279) @(negedge clk);
        issue(0, 1'b1, 5'd1, 5'd1, 16'h5555, 1'b0, 16'h0000, 1'b0);
        repeat (40) @(negedge clk);
        chk("ignored_busy", {63'd0, busy_a}, 64'd0);
        chk("ignored_frames", frames[0] - f0, 64'd1);

        // asynchronous reset mid-frame
        issue(0, 1'b0, 5'd0, 5'd2, 16'h0000, 1'b0, 16'h0000, 1'b0);
        a0 = cyc;
        while (cyc < a0 + 312) @(negedge clk);
        chk("pre_rst_mdc", {63'd0, mdc_a}, 64'd1);
        chk("pre_rst_busy", {63'd0, busy_a}, 64'd1);
        rst_v[0] = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy_a}, 64'd0);
        chk("midrst_mdc", {63'd0, mdc_a}, 64'd0);
        chk("midrst_mdio", {63'd0, mdio_a}, 64'd1);
        chk("midrst_rdata", {48'd0, rdata_a}, 64'd0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        repeat (3) @(negedge clk);

        issue(0, 1'b0, 5'd0, 5'd2, 16'h0000, 1'b1, 16'h1234, 1'b0);
        wait_idle(0, "read_after_rst");
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management frame engine: on a single-cycle start request it serialises one 64-bit read or write frame to the VSC PHY over MDC/MDIO and returns the read data. It sits directly upstream of the register-read/UART reporting logic. That logic supplies the PHY and register address, consumes `o_rdata`/`o_done`, and forwards the value to `o_tx`. One instance owns the board's MDC/MDIO pins.

## Interface
- `CLK_DIV`, default 10: `clk` cycles per MDC half-period; legal values ≥1; MDC = `clk` / (2·`CLK_DIV`).
- `clk`  in  1  system clock; all logic on its rising edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `i_start`  in  1  start request, sampled each `clk`; accepted only when idle.
- `i_write`  in  1  1 = write frame, 0 = read frame; latched on accept.
- `i_phy_addr`  in  5  PHYAD; latched on accept.
- `i_reg_addr`  in  5  REGAD; latched on accept.
- `i_wdata`  in  16  write data; latched on accept.
- `o_rdata`  out  16  last read data; updated only at the end of a read frame.
- `o_done`  out  1  one-cycle pulse at frame end.
- `o_busy`  out  1  frame in progress.
- `o_err`  out  1  read got no PHY turnaround; valid with `o_done`, holds until next accept.
- `o_mdc`  out  1  management clock.
- `io_mdio`  inout  1  management data; tri-stated when not driving; external pull-up.

## Operation
- States: IDLE, PREAMBLE (bits 0–31), HEADER (bits 32–45), TA (bits 46–47), DATA (bits 48–63), then back to IDLE.
- Bit counter: 6 bits, 0..63. Half-period divider: counts 0..`CLK_DIV`−1.
- Frame, MSB first:
  - 32×'1'
  - ST = 01
  - OP = 10 (read) or 01 (write)
  - PHYAD[4:0], REGAD[4:0]
  - TA = "10" (write); released (read)
  - DATA[15:0]
- Output enable:
  - Bits 0–45: driven.
  - Write: also driven on bits 46–63.
  - Read: released from bit 46 onward.
  - IDLE: released.
- Read sampling: `io_mdio` is sampled on each `clk` edge where `o_mdc` rises.
  - Bit 47: sampled value 1 → `o_err`=1 at frame end; otherwise 0.
  - Bits 48–63: shifted into a 16-bit register, MSB first.
  - At frame end, a read copies the shift register to `o_rdata`.
  - A write leaves `o_rdata` and `o_err` unchanged, except that `o_err` is cleared on accept.
- `i_start` while busy, or in the `o_done` cycle: ignored, no queuing.
- Reset values: `o_mdc`=0, `io_mdio`=Z, `o_busy`=0, `o_done`=0, `o_rdata`=0, `o_err`=0, state IDLE.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); the partial frame is abandoned; no `o_done`.

## Timing
- Edge A: `i_start`=1 with state IDLE.
  - `o_busy`=1 from A.
  - Bit 0 is driven from A.
  - `o_mdc` is low.
- Each bit lasts 2·`CLK_DIV` cycles:
  - `o_mdc` low for the first `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `o_mdc` rises at A + (2k+1)·`CLK_DIV`.
  - The next bit's MDIO value changes on the same edge that `o_mdc` falls.
- Frame end at edge A + 128·`CLK_DIV`:
  - `o_mdc`=0, `io_mdio`=Z.
  - `o_busy`=0.
  - `o_done`=1 for exactly one cycle; `o_rdata`/`o_err` valid on the same edge.
- Earliest next accept: A + 128·`CLK_DIV` + 1.
- `CLK_DIV`=1: MDC toggles every `clk`; frame = 128 cycles.

## Test plan
- Read, `CLK_DIV`=10, PHY model at address 0 returns 0x1234 for reg 2, `i_phy_addr`=0, `i_reg_addr`=2:
  - Bits 0–45 match 32×1, 0110, 00000, 00010.
  - `o_done` at A+1280.
  - `o_rdata`=0x1234, `o_err`=0.
- Write, `i_phy_addr`=3, `i_reg_addr`=0x1F, `i_wdata`=0xA5C3:
  - PHY model captures OP=01, TA=10, data 0xA5C3 on MDC rising edges.
  - `o_rdata` unchanged.
  - MDIO driven for all 64 bits.
- Read with no PHY (pull-up only) → `o_rdata`=0xFFFF, `o_err`=1.
- `i_start` pulsed at A+5 and in the `o_done` cycle → both ignored; exactly one frame and one `o_done`.
- `i_reset_n` low at A+300 → `o_busy`/`o_mdc`=0 and `io_mdio`=Z that same cycle; no `o_done`. A new read after release completes normally.
- `CLK_DIV`=1 read of 0x8001 → MDC period 2 `clk`, `o_done` at A+128, `o_rdata`=0x8001.
